nibble_cmp_seq: RTL and testbench

Sequencer that compares two multi-nibble unsigned operands by stepping a shared 4-bit magnitude comparator (E/G/L outputs) from the most-significant nibble down. It terminates early at the first unequal nibble. It sits between a requesting datapath and one comparator instance, so one small comparator can serve wide operands. Start/busy/done handshake; results are held until the next completion.

---
 rtl/nibble_cmp_seq.sv | 109 ++++++++++
 tb/tb_nibble_cmp_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_cmp_seq.sv
// Compares wide unsigned operands through one external 4-bit comparator, MSB nibble first, stopping at the first difference.
// Latency k+1 cycles (k = nibbles examined); start is ignored while busy, results hold until the next completion.
module nibble_cmp_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  output logic                   busy,
  output logic                   done,
  output logic                   gt,
  output logic                   lt,
  output logic                   eq,
  output logic [3:0]             cmp_a,
  output logic [3:0]             cmp_b,
  input  logic                   cmp_g,
  input  logic                   cmp_l,
  input  logic                   cmp_e
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            idx   <= LAST_IDX;
          end
        end
        S_RUN: begin
          // equality wins over g/l; inconsistent comparator outputs are not policed
          if (cmp_e) begin
            if (idx != '0) begin
              idx <= idx - IW'(1);
            end else begin
              gt <= 1'b0;
              lt <= 1'b0;
              eq <= 1'b1;
            end
          end else begin
            gt <= cmp_g;
            lt <= cmp_l;
            eq <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = (cmp_e && idx != '0) ? S_RUN : S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    cmp_a = 4'd0;
    cmp_b = 4'd0;
    a_sh  = a_reg >> {idx, 2'b00};
    b_sh  = b_reg >> {idx, 2'b00};
    case (state)
      S_RUN: begin
        busy  = 1'b1;
        cmp_a = a_sh[3:0];
        cmp_b = b_sh[3:0];
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Bench for nibble_cmp_seq: directed scenarios plus randomized start/operands/reset against a cycle-count model.
module tb_nibble_cmp_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          busy, done, gt, lt, eq;
  logic [3:0]    cmp_a, cmp_b;
  logic          cmp_g, cmp_l, cmp_e;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  nibble_cmp_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g), .cmp_l(cmp_l), .cmp_e(cmp_e)
  );

  // the shared comparator lives in the bench
  assign cmp_g = cmp_a > cmp_b;
  assign cmp_l = cmp_a < cmp_b;
  assign cmp_e = cmp_a == cmp_b;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: an operation is active for positions 1..k (comparing) and k+1 (publishing)
  bit           m_act = 1'b0;
  int           m_pos = 0;
  int           m_k = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  bit           p_gt, p_lt, p_eq;
  bit           m_gt = 1'b0, m_lt = 1'b0, m_eq = 1'b0;
  bit           m_acc, m_found;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0; m_pos = 0; m_k = 0; m_a = '0; m_b = '0;
      m_gt = 1'b0; m_lt = 1'b0; m_eq = 1'b0;
    end else begin
      m_acc = start && !(m_act && m_pos <= m_k);
      if (m_act) begin
        m_pos++;
        if (m_pos == m_k + 1) begin
          m_gt = p_gt; m_lt = p_lt; m_eq = p_eq;
        end else if (m_pos > m_k + 1) begin
          m_act = 1'b0;
        end
      end
      if (m_acc) begin
        m_a = a_in; m_b = b_in;
        m_k = N; m_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
          if (!m_found && (((m_a >> (4*i)) & 16'hF) != ((m_b >> (4*i)) & 16'hF))) begin
            m_k = N - i;
            m_found = 1'b1;
          end
        end
        p_gt = m_a > m_b; p_lt = m_a < m_b; p_eq = m_a == m_b;
        m_act = 1'b1; m_pos = 1;
      end
    end
  end

  logic         e_busy, e_done;
  logic [W-1:0] e_as, e_bs;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = m_act && m_pos >= 1 && m_pos <= m_k;
      e_done = m_act && m_pos == m_k + 1;
      e_as = e_busy ? (m_a >> (4*(N - m_pos))) : '0;
      e_bs = e_busy ? (m_b >> (4*(N - m_pos))) : '0;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("gt", gt, m_gt);
      chk("lt", lt, m_lt);
      chk("eq", eq, m_eq);
      chk("cmp_a", cmp_a, e_as[3:0]);
      chk("cmp_b", cmp_b, e_bs[3:0]);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int nb, output logic [31:0] sa, output logic [31:0] sb);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    lat = 0; nb = 0; sa = '0; sb = '0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) begin
        nb++;
        sa = {sa[27:0], cmp_a};
        sb = {sb[27:0], cmp_b};
      end
    end while (!done && lat < 20);
    chk("op_done_seen", done, 1);
  endtask

  int lat, nb;
  logic [31:0] sa, sb;

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmp_a", cmp_a, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_res", {gt, lt, eq}, 0);
      chk("idle_cmp", {cmp_a, cmp_b}, 0);
    end

    run_op(16'h9000, 16'h1FFF, lat, nb, sa, sb);
    chk("top_lat", lat, 2);
    chk("top_runs", nb, 1);
    chk("top_cmp_a", sa, 32'h9);
    chk("top_cmp_b", sb, 32'h1);
    chk("top_res", {gt, lt, eq}, 3'b100);

    run_op(16'hA5C3, 16'hA5C3, lat, nb, sa, sb);
    chk("eq_lat", lat, 5);
    chk("eq_runs", nb, 4);
    chk("eq_seq", sa, 32'hA5C3);
    chk("eq_res", {gt, lt, eq}, 3'b001);

    run_op(16'h1234, 16'h1235, lat, nb, sa, sb);
    chk("low_runs", nb, 4);
    chk("low_res", {gt, lt, eq}, 3'b010);

    // start and a_in changes during RUN must be ignored
    @(negedge clk);
    start = 1'b1; a_in = 16'h0001; b_in = 16'h0002; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        start = 1'b1; a_in = 16'hFFFF; b_in = 16'h0000;
      end
    end while (!done && lat < 20);
    chk("hs_lat", lat, 5);
    chk("hs_res", {gt, lt, eq}, 3'b010);
    start = 1'b1; a_in = 16'h00F0; b_in = 16'h000F;
    lat = 0; nb = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) nb++;
    end while (!done && lat < 20);
    chk("b2b_runs", nb, 3);
    chk("b2b_lat", lat, 4);
    chk("b2b_res", {gt, lt, eq}, 3'b100);

    @(negedge clk);
    start = 1'b1; a_in = 16'h7777; b_in = 16'h7777;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_res", {done, gt, lt, eq}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    run_op(16'h7777, 16'h7777, lat, nb, sa, sb);
    chk("rerun_lat", lat, 5);
    chk("rerun_res", {gt, lt, eq}, 3'b001);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      start = $urandom_range(0, 1) != 0;
      a_in  = W'($urandom);
      case ($urandom_range(0, 2))
        0:       b_in = a_in;
        1:       b_in = a_in ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
        default: b_in = W'($urandom);
      endcase
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
